// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared register width and sequencer state encoding
package hazard_stall_ctrl_pkg;
    localparam int REG_W = 4;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM hazard inputs and pipeline freeze/flush controls
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rdm;
    logic             id_two_src;
    logic [REG_W-1:0] ex_dest;
    logic             ex_wb_en;
    logic             ex_mem_read;
    logic             ex_branch;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             hazard;
    logic             flush;
    logic             freeze_all;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rn, id_rdm, id_two_src, ex_dest, ex_wb_en, ex_mem_read, ex_branch,
               mem_dest, mem_wb_en, mem_req, mem_ready, cnt_clr,
        input  hazard, flush, freeze_all, mem_err, stall_cnt
    );

    modport slave (
        input  id_rn, id_rdm, id_two_src, ex_dest, ex_wb_en, ex_mem_read, ex_branch,
               mem_dest, mem_wb_en, mem_req, mem_ready, cnt_clr,
        output hazard, flush, freeze_all, mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl_raw_detect.sv
// raw_detect: read-after-write compare of ID sources against EX/MEM destinations
module raw_detect
    import hazard_stall_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b0
) (
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rdm,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             raw_haz
);
    logic raw_ex;
    logic raw_mem;

    // With forwarding only a load in EX cannot be bypassed in time
    always_comb begin
        raw_ex  = ex_wb_en & ((id_rn == ex_dest) | (id_two_src & (id_rdm == ex_dest)));
        raw_mem = mem_wb_en & ((id_rn == mem_dest) | (id_two_src & (id_rdm == mem_dest)));
        raw_haz = FWD_EN ? (raw_ex & ex_mem_read) : (raw_ex | raw_mem);
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/freeze sequencer with memory timeout and stall counter
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter bit FWD_EN      = 1'b0,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t          state;
    state_t          state_nx;
    logic [WC_W-1:0] wait_cnt;
    logic            raw_haz;
    logic            freeze;
    logic            timeout;

    raw_detect #(.FWD_EN(FWD_EN)) u_raw (
        .id_rn       (bus.id_rn),
        .id_rdm      (bus.id_rdm),
        .id_two_src  (bus.id_two_src),
        .ex_dest     (bus.ex_dest),
        .ex_wb_en    (bus.ex_wb_en),
        .ex_mem_read (bus.ex_mem_read),
        .mem_dest    (bus.mem_dest),
        .mem_wb_en   (bus.mem_wb_en),
        .raw_haz     (raw_haz)
    );

    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    // Next state and same-cycle controls; freeze beats branch flush beats RAW stall
    always_comb begin
        state_nx = state;
        freeze   = 1'b1;
        case (state)
            ST_RUN: begin
                freeze   = bus.mem_req & ~bus.mem_ready;
                state_nx = freeze ? ST_MEM_WAIT : ST_RUN;
            end
            ST_MEM_WAIT: begin
                freeze   = ~bus.mem_ready;
                state_nx = bus.mem_ready ? ST_RUN : (timeout ? ST_ERR : ST_MEM_WAIT);
            end
            default: state_nx = ST_ERR;
        endcase
        bus.freeze_all = freeze & ~rst;
        bus.flush      = ~freeze & ~rst & bus.ex_branch;
        bus.hazard     = ~freeze & ~rst & ~bus.ex_branch & raw_haz;
    end

    // State register, wait counter restarted outside MEM_WAIT, sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            bus.mem_err <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= (state == ST_MEM_WAIT) ? wait_cnt + 1'b1 : '0;
            bus.mem_err <= bus.mem_err | (state_nx == ST_ERR);
        end
    end

    // Saturating stall-cycle counter; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.stall_cnt <= '0;
        else if (bus.cnt_clr)
            bus.stall_cnt <= '0;
        else if ((bus.hazard | bus.freeze_all) && (bus.stall_cnt != {CNT_W{1'b1}}))
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
endmodule
